traffic_lanes: RTL and testbench

TRAFFIC_LANES -- requirements
Module: traffic_lanes

---
 rtl/traffic_lanes.sv | 86 ++++++++
 tb/tb_traffic_lanes.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lanes.sv
// Scrolling car lanes with LFSR-driven spawning, frog collision detect and exit counter.
// Lanes, tick, hit and cars_passed are all registered; no flow control, enable freezes advance.
module traffic_lanes #(
    parameter int N     = 16,
    parameter int LANES = 4,
    parameter int DIV_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_W-1:0]     period,
    input  logic [9:0]           density,
    input  logic [LANES-1:0]     dir,
    input  logic [LANES-1:0]     lane_clear,
    input  logic [LANES-1:0]     frog_row,
    input  logic [N-1:0]         frog_col,
    output logic [LANES*N-1:0]   lanes,
    output logic                 tick,
    output logic                 hit,
    output logic [15:0]          cars_passed
);

    logic [9:0]         r;
    logic [DIV_W-1:0]   cnt;
    logic               adv;
    logic [LANES*N-1:0] lanes_nxt;
    logic [3:0]         exits;
    logic               hit_nxt;
    logic [16:0]        cars_sum;
    logic [19:0]        rr;
    logic [9:0]         rnd;
    logic [N-1:0]       q;
    logic               spawn;

    assign adv = enable && (cnt == period);

    always_comb begin
        lanes_nxt = lanes;
        exits     = 4'd0;
        hit_nxt   = 1'b0;
        rr        = '0;
        rnd       = '0;
        q         = '0;
        spawn     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            q       = lanes[i*N +: N];
            hit_nxt = hit_nxt | (frog_row[i] & (|(q & frog_col)));
            // Per-lane random value: LFSR rotated left by (3*i mod 10).
            rr      = {r, r} << ((3 * i) % 10);
            rnd     = rr[19:10];
            spawn   = (density > rnd) && (dir[i] ? !q[N-1] : !q[0]);
            if (lane_clear[i]) begin
                lanes_nxt[i*N +: N] = '0;
            end else if (adv) begin
                if (dir[i]) begin
                    if (q[0]) exits = exits + 4'd1;
                    lanes_nxt[i*N +: N] = {spawn, q[N-1:1]};
                end else begin
                    if (q[N-1]) exits = exits + 4'd1;
                    lanes_nxt[i*N +: N] = {q[N-2:0], spawn};
                end
            end
        end
        cars_sum = {1'b0, cars_passed} + {13'd0, exits};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r           <= '0;
            cnt         <= '0;
            lanes       <= '0;
            tick        <= 1'b0;
            hit         <= 1'b0;
            cars_passed <= '0;
        end else begin
            // XNOR feedback: the all-zero reset state is legal, all-ones is the lockup.
            r     <= {~(r[0] ^ r[3]), r[9:1]};
            tick  <= adv;
            hit   <= hit_nxt;
            lanes <= lanes_nxt;
            if (enable) cnt <= adv ? '0 : cnt + 1'b1;
            cars_passed <= cars_sum[16] ? 16'hFFFF : cars_sum[15:0];
        end
    end

endmodule

// File: tb/tb_traffic_lanes.sv
// Directed stimulus against a behavioural lane model; expectations queued per cycle.
module tb_traffic_lanes;
    localparam int N     = 16;
    localparam int LANES = 4;
    localparam int DIV_W = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [DIV_W-1:0]     period;
    logic [9:0]           density;
    logic [LANES-1:0]     dir;
    logic [LANES-1:0]     lane_clear;
    logic [LANES-1:0]     frog_row;
    logic [N-1:0]         frog_col;
    logic [LANES*N-1:0]   lanes;
    logic                 tick;
    logic                 hit;
    logic [15:0]          cars_passed;

    always #5 clk = ~clk;

    traffic_lanes #(.N(N), .LANES(LANES), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period),
        .density(density), .dir(dir), .lane_clear(lane_clear),
        .frog_row(frog_row), .frog_col(frog_col), .lanes(lanes),
        .tick(tick), .hit(hit), .cars_passed(cars_passed)
    );

    typedef struct packed {
        logic [LANES*N-1:0] lanes;
        logic               tick;
        logic               hit;
        logic [15:0]        cars;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    logic [9:0]   m_r = '0;
    int           m_cnt = 0;
    logic [N-1:0] m_q [LANES];
    logic         m_tick = 1'b0;
    logic         m_hit = 1'b0;
    int           m_cars = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [9:0]         rnd;
        logic [N-1:0]       q;
        logic               adv;
        logic               hn;
        logic               sp;
        int                 ex;
        exp_t               e;
        if (reset) begin
            m_r = '0; m_cnt = 0; m_tick = 1'b0; m_hit = 1'b0; m_cars = 0;
            for (int i = 0; i < LANES; i++) m_q[i] = '0;
        end else begin
            hn = 1'b0;
            for (int i = 0; i < LANES; i++)
                if (frog_row[i] && ((m_q[i] & frog_col) != '0)) hn = 1'b1;
            adv = enable && (m_cnt == int'(period));
            ex = 0;
            for (int i = 0; i < LANES; i++) begin
                rnd = '0;
                for (int b = 0; b < 10; b++) rnd[(b + (3 * i) % 10) % 10] = m_r[b];
                q  = m_q[i];
                sp = (density > rnd) && (dir[i] ? (q[N-1] == 1'b0) : (q[0] == 1'b0));
                if (lane_clear[i]) q = '0;
                else if (adv) begin
                    if (dir[i]) begin
                        ex += int'(q[0]);
                        q = {sp, q[N-1:1]};
                    end else begin
                        ex += int'(q[N-1]);
                        q = {q[N-2:0], sp};
                    end
                end
                m_q[i] = q;
            end
            m_cars = (m_cars + ex > 65535) ? 65535 : m_cars + ex;
            m_r    = {m_r[0] ~^ m_r[3], m_r[9:1]};
            if (enable) m_cnt = adv ? 0 : (m_cnt + 1) % 256;
            m_tick = adv;
            m_hit  = hn;
        end
        for (int i = 0; i < LANES; i++) e.lanes[i*N +: N] = m_q[i];
        e.tick = m_tick;
        e.hit  = m_hit;
        e.cars = 16'(m_cars);
        sbq.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("lanes", 64'(lanes), 64'(e.lanes));
        check("tick", 64'(tick), 64'(e.tick));
        check("hit", 64'(hit), 64'(e.hit));
        check("cars_passed", 64'(cars_passed), 64'(e.cars));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [15:0] t34 [4] = '{16'h0001, 16'h0002, 16'h0005, 16'h000A};
    logic [15:0] t35 [4] = '{16'h8000, 16'h4000, 16'hA000, 16'h5000};
    logic [9:0]  tr  [3] = '{10'h200, 10'h300, 10'h380};

    initial begin
        int              nticks;
        int              guard;
        logic [LANES*N-1:0] snap;

        reset = 1'b1; enable = 1'b0; period = '0; density = '0;
        dir = '0; lane_clear = '0; frog_row = '0; frog_col = '0;
        step();
        step();
        check("reset_lanes", 64'(lanes), 64'd0);
        check("reset_cars", 64'(cars_passed), 64'd0);

        // LFSR start-up sequence with the game frozen
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("lfsr_seq", 64'(dut.r), 64'(tr[k]));
        end

        // Density 0: never spawns, tick every cycle
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("s33_tick", 64'(tick), 64'd1);
        end
        check("s33_lanes", 64'(lanes), 64'd0);
        check("s33_cars", 64'(cars_passed), 64'd0);

        // Full density toward MSB
        enable = 1'b0;
        do_reset();
        density = 10'h3FF; dir = 4'b0000; enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("s34_lane0", 64'(lanes[15:0]), 64'(t34[k]));
        end

        // Collision against lane0 = 0005
        enable = 1'b0;
        do_reset();
        enable = 1'b1;
        repeat (3) step();
        check("s37_lane0", 64'(lanes[15:0]), 64'h0005);
        enable = 1'b0; frog_row = 4'b0001; frog_col = 16'h0004;
        step();
        check("s37_hit", 64'(hit), 64'd1);
        frog_col = 16'h0002;
        step();
        check("s37_miss", 64'(hit), 64'd0);
        frog_col = 16'h0000; frog_row = 4'b0001;
        step();
        check("s37_col_zero", 64'(hit), 64'd0);
        frog_col = 16'h0004; frog_row = 4'b0000;
        step();
        check("s37_row_zero", 64'(hit), 64'd0);
        frog_row = '0; frog_col = '0;

        // Full density toward LSB
        do_reset();
        dir = 4'b0001; enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("s35_lane0", 64'(lanes[15:0]), 64'(t35[k]));
        end

        // Period 3, then a 5-cycle freeze
        enable = 1'b0;
        do_reset();
        period = 8'd3; dir = 4'b0000; enable = 1'b1;
        nticks = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (tick) nticks++;
        end
        check("s36_tick_count", 64'(nticks), 64'd3);
        step();
        enable = 1'b0;
        snap = lanes;
        for (int k = 0; k < 5; k++) begin
            step();
            check("s36_frozen_lanes", 64'(lanes), 64'(snap));
            check("s36_frozen_tick", 64'(tick), 64'd0);
            check("s36_frozen_cnt", 64'(dut.cnt), 64'(m_cnt));
        end
        enable = 1'b1;
        repeat (8) step();

        // Clear one lane coincident with a tick, then drive the counter into saturation
        enable = 1'b0;
        do_reset();
        period = '0; dir = 4'b0101; enable = 1'b1;
        repeat (40) step();
        lane_clear = 4'b0010;
        step();
        check("s38_lane1_clear", 64'(lanes[31:16]), 64'd0);
        lane_clear = '0;
        guard = 0;
        while (m_cars < 65535 && guard < 40000) begin
            step();
            guard++;
        end
        check("s38_sat_in_budget", 64'(guard < 40000), 64'd1);
        repeat (5) step();
        check("s38_saturated", 64'(cars_passed), 64'hFFFF);

        // Reset mid-run overrides clear and tick
        reset = 1'b1; lane_clear = 4'b1111;
        step();
        check("midreset_lanes", 64'(lanes), 64'd0);
        check("midreset_cars", 64'(cars_passed), 64'd0);
        check("midreset_tick", 64'(tick), 64'd0);
        reset = 1'b0; lane_clear = '0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
